// File: rtl/aes_pkg.sv
// Shared AES definitions: dimensions, mode encodings, round-count lookup,
// S-box table and GF(2^8) helpers used by the round ladder and its round logic.
package aes_pkg;

    localparam int NB_BYTE      = 8;
    localparam int N_BYTES      = 16;
    localparam int N_ROWS       = 4;
    localparam int N_COLS       = N_BYTES / N_ROWS;
    localparam int NB_STATE     = N_BYTES * NB_BYTE;
    localparam int N_ROUNDS_MAX = 14;
    localparam int NB_RND       = $clog2(N_ROUNDS_MAX + 1);
    localparam int NB_KEY_VEC   = NB_STATE * (N_ROUNDS_MAX + 1);

    typedef enum logic [1:0] {
        MODE_AES128  = 2'b00,
        MODE_AES192  = 2'b01,
        MODE_AES256  = 2'b10,
        MODE_ILLEGAL = 2'b11
    } aes_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ladder_state_e;

    localparam logic [NB_RND-1:0] NR_AES128 = 4'd10;
    localparam logic [NB_RND-1:0] NR_AES192 = 4'd12;
    localparam logic [NB_RND-1:0] NR_AES256 = 4'd14;
    localparam logic [NB_RND-1:0] NR_NONE   = 4'd0;
    localparam logic [NB_RND-1:0] NR_LIMIT  = NB_RND'(N_ROUNDS_MAX);
    localparam logic [NB_RND-1:0] RND_ZERO  = 4'd0;
    localparam logic [NB_RND-1:0] RND_ONE   = 4'd1;

    // Forward S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round count for a key-length mode; zero marks an unsupported mode.
    function automatic logic [NB_RND-1:0] mode_to_nr(input logic [1:0] mode);
        logic [NB_RND-1:0] nr;
        case (mode)
            MODE_AES128: nr = NR_AES128;
            MODE_AES192: nr = NR_AES192;
            MODE_AES256: nr = NR_AES256;
            default:     nr = NR_NONE;
        endcase
        return nr;
    endfunction

    function automatic logic [NB_BYTE-1:0] sbox(input logic [NB_BYTE-1:0] b);
        logic [10:0] idx;
        idx = 11'd2047 - {b, 3'b000};
        return SBOX_TABLE[idx -: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [NB_BYTE-1:0] xtime(input logic [NB_BYTE-1:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One full AES round as pure combinational logic:
// SubBytes -> ShiftRows -> MixColumns (skipped on the last round) -> AddRoundKey.
// State byte s(r,c) sits at index r + 4c, index 0 in the most significant byte.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [NB_STATE-1:0] i_state,
    input  logic [NB_STATE-1:0] i_round_key,
    input  logic                i_last_stage_flag,
    output logic [NB_STATE-1:0] o_state
);

    logic [NB_BYTE-1:0] sub_s   [N_BYTES];
    logic [NB_BYTE-1:0] shift_s [N_BYTES];
    logic [NB_BYTE-1:0] mix_s   [N_BYTES];

    for (genvar i = 0; i < N_BYTES; i++) begin : g_sub
        assign sub_s[i] = sbox(i_state[NB_STATE-1-NB_BYTE*i -: NB_BYTE]);
    end

    // Row r rotates left by r columns.
    for (genvar c = 0; c < N_COLS; c++) begin : g_shift_col
        for (genvar r = 0; r < N_ROWS; r++) begin : g_shift_row
            assign shift_s[N_ROWS*c+r] = sub_s[N_ROWS*((c+r)%N_COLS)+r];
        end
    end

    for (genvar c = 0; c < N_COLS; c++) begin : g_mix
        logic [NB_BYTE-1:0] a0_s, a1_s, a2_s, a3_s;
        assign a0_s = shift_s[N_ROWS*c+0];
        assign a1_s = shift_s[N_ROWS*c+1];
        assign a2_s = shift_s[N_ROWS*c+2];
        assign a3_s = shift_s[N_ROWS*c+3];
        assign mix_s[N_ROWS*c+0] = xtime(a0_s) ^ xtime(a1_s) ^ a1_s ^ a2_s ^ a3_s;
        assign mix_s[N_ROWS*c+1] = a0_s ^ xtime(a1_s) ^ xtime(a2_s) ^ a2_s ^ a3_s;
        assign mix_s[N_ROWS*c+2] = a0_s ^ a1_s ^ xtime(a2_s) ^ xtime(a3_s) ^ a3_s;
        assign mix_s[N_ROWS*c+3] = xtime(a0_s) ^ a0_s ^ a1_s ^ a2_s ^ xtime(a3_s);
    end

    for (genvar i = 0; i < N_BYTES; i++) begin : g_ark
        assign o_state[NB_STATE-1-NB_BYTE*i -: NB_BYTE] =
            (i_last_stage_flag ? shift_s[i] : mix_s[i]) ^
            i_round_key[NB_STATE-1-NB_BYTE*i -: NB_BYTE];
    end

endmodule

// File: rtl/aes_round_ladder_multimode.sv
// Iterative AES encryption ladder: one round per enabled clock, key length
// chosen per launch (10/12/14 rounds). Inputs are latched at launch so the
// upstream key expansion and plaintext source are free to move on. A new
// block may launch in the final-round cycle of the previous one.
module aes_round_ladder_multimode
    import aes_pkg::*;
(
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic                  i_trigger,
    input  logic [1:0]            i_mode,
    input  logic [NB_STATE-1:0]   i_state,
    input  logic [NB_KEY_VEC-1:0] i_round_key_vector,
    output logic [NB_STATE-1:0]   o_state,
    output logic                  o_state_ready,
    output logic                  o_busy,
    output logic                  o_mode_error
);

    ladder_state_e         fsm_state_r;
    logic [NB_RND-1:0]     rnd_r;
    logic [NB_RND-1:0]     nr_r;
    logic [NB_KEY_VEC-1:0] key_vec_r;
    logic [NB_STATE-1:0]   block_r;
    logic [NB_STATE-1:0]   out_state_r;
    logic                  state_ready_r;
    logic                  mode_error_r;

    logic [NB_STATE-1:0]   key_arr_s [N_ROUNDS_MAX+1];
    logic [NB_STATE-1:0]   round_key_s;
    logic [NB_STATE-1:0]   round_out_s;
    logic [NB_RND-1:0]     mode_nr_s;
    logic                  mode_ok_s;
    logic                  last_round_s;
    logic                  busy_s;
    logic                  launch_req_s;
    logic                  accept_s;
    logic                  reject_s;

    for (genvar k = 0; k <= N_ROUNDS_MAX; k++) begin : g_key_split
        assign key_arr_s[k] = key_vec_r[k*NB_STATE +: NB_STATE];
    end

    assign round_key_s  = key_arr_s[rnd_r];

    // Busy depends only on registers, releasing in the final-round cycle.
    assign last_round_s = (fsm_state_r == ST_RUN) && (rnd_r == nr_r);
    assign busy_s       = (fsm_state_r == ST_RUN) && !last_round_s;

    assign mode_nr_s    = mode_to_nr(i_mode);
    assign mode_ok_s    = (mode_nr_s != NR_NONE) && (mode_nr_s <= NR_LIMIT);
    assign launch_req_s = i_valid && i_trigger && !busy_s;
    assign accept_s     = launch_req_s && mode_ok_s;
    assign reject_s     = launch_req_s && !mode_ok_s;

    aes_round_comb u_round (
        .i_state           (block_r),
        .i_round_key       (round_key_s),
        .i_last_stage_flag (last_round_s),
        .o_state           (round_out_s)
    );

    // Launch control, round iteration and registered outputs; everything holds while i_valid is low.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            fsm_state_r   <= ST_IDLE;
            rnd_r         <= RND_ZERO;
            nr_r          <= NR_NONE;
            key_vec_r     <= {NB_KEY_VEC{1'b0}};
            block_r       <= {NB_STATE{1'b0}};
            out_state_r   <= {NB_STATE{1'b0}};
            state_ready_r <= 1'b0;
            mode_error_r  <= 1'b0;
        end else if (i_valid) begin
            state_ready_r <= 1'b0;
            mode_error_r  <= reject_s;
            case (fsm_state_r)
                ST_IDLE: begin
                    fsm_state_r <= ST_IDLE;
                end
                ST_RUN: begin
                    block_r <= round_out_s;
                    if (last_round_s) begin
                        out_state_r   <= round_out_s;
                        state_ready_r <= 1'b1;
                        fsm_state_r   <= ST_IDLE;
                        rnd_r         <= RND_ZERO;
                    end else begin
                        rnd_r <= rnd_r + RND_ONE;
                    end
                end
                default: begin
                    fsm_state_r <= ST_IDLE;
                    rnd_r       <= RND_ZERO;
                end
            endcase
            // A launch overrides the round update, including in the final-round cycle.
            if (accept_s) begin
                key_vec_r   <= i_round_key_vector;
                nr_r        <= mode_nr_s;
                block_r     <= i_state ^ i_round_key_vector[NB_STATE-1:0];
                rnd_r       <= RND_ONE;
                fsm_state_r <= ST_RUN;
            end
        end
    end

    assign o_state       = out_state_r;
    assign o_state_ready = state_ready_r;
    assign o_busy        = busy_s;
    assign o_mode_error  = mode_error_r;

endmodule

// File: tb/tb_aes_round_ladder_multimode.sv
// Self-checking bench for aes_round_ladder_multimode. Expected ciphertexts come
// from FIPS-197 constants and from a byte-matrix AES model built here from GF(2^8)
// arithmetic (S-box derived from inversion plus affine map).
module tb_aes_round_ladder_multimode;

    localparam int NB_ST = 128;
    localparam int NB_KV = 1920;

    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic             i_clock = 1'b0;
    logic             i_reset;
    logic             i_valid;
    logic             i_trigger;
    logic [1:0]       i_mode;
    logic [NB_ST-1:0] i_state;
    logic [NB_KV-1:0] i_round_key_vector;
    logic [NB_ST-1:0] o_state;
    logic             o_state_ready;
    logic             o_busy;
    logic             o_mode_error;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb [256];

    always #5 i_clock = ~i_clock;

    aes_round_ladder_multimode dut (
        .i_clock            (i_clock),
        .i_reset            (i_reset),
        .i_valid            (i_valid),
        .i_trigger          (i_trigger),
        .i_mode             (i_mode),
        .i_state            (i_state),
        .i_round_key_vector (i_round_key_vector),
        .o_state            (o_state),
        .o_state_ready      (o_state_ready),
        .o_busy             (o_busy),
        .o_mode_error       (o_mode_error)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, r;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv;
            r = inv;
            for (int k = 1; k <= 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sb[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [NB_KV-1:0] rand_kv();
        logic [NB_KV-1:0] kv;
        for (int k = 0; k < 15; k++) kv[k*128 +: 128] = rand128();
        return kv;
    endfunction

    // Key schedule for Nk words; round keys past Nr are filled with noise.
    function automatic logic [NB_KV-1:0] expand_key(input logic [255:0] key, input int nk);
        logic [31:0]      w [60];
        logic [31:0]      t;
        logic [7:0]       rcon = 8'h01;
        logic [NB_KV-1:0] kv;
        int               nr = nk + 6;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                    rcon = gf_mul(rcon, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int k = 0; k < 15; k++) begin
            if (k <= nr) kv[k*128 +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
            else         kv[k*128 +: 128] = rand128();
        end
        return kv;
    endfunction

    function automatic logic [127:0] ref_cipher(input logic [127:0] pt, input logic [NB_KV-1:0] kv, input int nr);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] rk;
        logic [127:0] ct;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r][c] = pt[127-8*(r+4*c) -: 8];
        for (int rd = 0; rd <= nr; rd++) begin
            if (rd > 0) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][(c+r)%4]];
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        if (rd < nr)
                            s[r][c] = gf_mul(8'h02, t[r][c]) ^ gf_mul(8'h03, t[(r+1)%4][c]) ^
                                      t[(r+2)%4][c] ^ t[(r+3)%4][c];
                        else
                            s[r][c] = t[r][c];
            end
            rk = kv[rd*128 +: 128];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ rk[127-8*(r+4*c) -: 8];
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) ct[127-8*(r+4*c) -: 8] = s[r][c];
        return ct;
    endfunction

    // ---------------- bench helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic junk_inputs();
        i_trigger          = 1'b0;
        i_mode             = 2'($urandom_range(0, 3));
        i_state            = rand128();
        i_round_key_vector = rand_kv();
    endtask

    task automatic launch(input logic [1:0] mode, input logic [127:0] pt,
                          input logic [NB_KV-1:0] kv, input string tag);
        i_valid            = 1'b1;
        i_trigger          = 1'b1;
        i_mode             = mode;
        i_state            = pt;
        i_round_key_vector = kv;
        check({tag, " busy before launch"}, 128'(o_busy), 128'(0));
        step();
        junk_inputs();
    endtask

    // Advance until nr enabled edges after the launch, checking busy/ready/error each cycle.
    task automatic run_to_done(input int nr, input string tag, input bit stall, input bit noise,
                               input bit chain, input logic [1:0] cmode, input logic [127:0] cpt,
                               input logic [NB_KV-1:0] ckv);
        int n   = 0;
        int cyc = 0;
        bit v;
        while (n < nr && cyc < 400) begin
            v = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            junk_inputs();
            i_valid = v;
            if (chain && n == nr - 1) begin
                v                  = 1'b1;
                i_valid            = 1'b1;
                i_trigger          = 1'b1;
                i_mode             = cmode;
                i_state            = cpt;
                i_round_key_vector = ckv;
            end else if (noise && n < nr - 1) begin
                i_trigger = 1'($urandom_range(0, 1));
            end
            check({tag, " busy"}, 128'(o_busy), 128'(n < nr - 1));
            step();
            cyc++;
            if (v) n++;
            check({tag, " ready"}, 128'(o_state_ready), 128'(n == nr));
            check({tag, " mode_error"}, 128'(o_mode_error), 128'(0));
        end
        check({tag, " enabled edges"}, 128'(n), 128'(nr));
        i_trigger = 1'b0;
        i_valid   = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [255:0]     key;
        logic [NB_KV-1:0] kv128, kv192, kv256, kv_r;
        logic [127:0]     pt_r;
        int               mode_r;

        build_sbox();
        for (int i = 0; i < 32; i++) key[255-8*i -: 8] = 8'(i);
        kv128 = expand_key(key, 4);
        kv192 = expand_key(key, 6);
        kv256 = expand_key(key, 8);

        i_reset = 1'b1;
        i_valid = 1'b1;
        junk_inputs();
        i_trigger = 1'b1;
        step();
        step();
        check("reset o_state", o_state, 128'(0));
        check("reset ready", 128'(o_state_ready), 128'(0));
        check("reset busy", 128'(o_busy), 128'(0));
        check("reset mode_error", 128'(o_mode_error), 128'(0));
        i_reset   = 1'b0;
        i_trigger = 1'b0;

        // FIPS-197 vectors, exact latency with no stalls for AES-128
        launch(2'b00, PT_FIPS, kv128, "aes128");
        check("aes128 busy after launch", 128'(o_busy), 128'(1));
        run_to_done(10, "aes128", 1'b0, 1'b0, 1'b0, 2'b00, 128'(0), kv128);
        check("aes128 ciphertext", o_state, CT128);
        step();
        check("aes128 ready clears", 128'(o_state_ready), 128'(0));
        check("aes128 output held", o_state, CT128);

        launch(2'b01, PT_FIPS, kv192, "aes192");
        run_to_done(12, "aes192", 1'b1, 1'b1, 1'b0, 2'b00, 128'(0), kv192);
        check("aes192 ciphertext", o_state, CT192);

        launch(2'b10, PT_FIPS, kv256, "aes256");
        run_to_done(14, "aes256", 1'b1, 1'b1, 1'b0, 2'b00, 128'(0), kv256);
        check("aes256 ciphertext", o_state, CT256);

        // Back-to-back: AES-256 launched on the AES-128 final-round cycle
        launch(2'b00, PT_FIPS, kv128, "b2b first");
        run_to_done(10, "b2b first", 1'b0, 1'b0, 1'b1, 2'b10, PT_FIPS, kv256);
        check("b2b first ciphertext", o_state, CT128);
        check("b2b second busy", 128'(o_busy), 128'(1));
        run_to_done(14, "b2b second", 1'b0, 1'b0, 1'b0, 2'b00, 128'(0), kv256);
        check("b2b second ciphertext", o_state, CT256);

        // Illegal mode from IDLE
        i_valid   = 1'b1;
        i_trigger = 1'b1;
        i_mode    = 2'b11;
        i_state   = rand128();
        step();
        check("mode11 error strobe", 128'(o_mode_error), 128'(1));
        check("mode11 busy", 128'(o_busy), 128'(0));
        check("mode11 ready", 128'(o_state_ready), 128'(0));
        check("mode11 o_state held", o_state, CT256);
        i_trigger = 1'b0;
        i_valid   = 1'b0;
        step();
        step();
        check("mode11 error held in stall", 128'(o_mode_error), 128'(1));
        i_valid = 1'b1;
        step();
        check("mode11 error cleared", 128'(o_mode_error), 128'(0));
        check("mode11 still idle", 128'(o_busy), 128'(0));
        check("mode11 o_state unchanged", o_state, CT256);

        // Reset during round 5 of an AES-256 run
        launch(2'b10, PT_FIPS, kv256, "reset run");
        for (int i = 0; i < 4; i++) step();
        check("reset run busy at round 5", 128'(o_busy), 128'(1));
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        check("midrun reset o_state", o_state, 128'(0));
        check("midrun reset ready", 128'(o_state_ready), 128'(0));
        check("midrun reset busy", 128'(o_busy), 128'(0));
        check("midrun reset mode_error", 128'(o_mode_error), 128'(0));
        for (int i = 0; i < 16; i++) begin
            step();
            check("post reset no strobe", 128'(o_state_ready), 128'(0));
        end
        launch(2'b00, PT_FIPS, kv128, "post reset");
        run_to_done(10, "post reset", 1'b0, 1'b0, 1'b0, 2'b00, 128'(0), kv128);
        check("post reset ciphertext", o_state, CT128);

        // Randomized blocks against the reference model
        for (int t = 0; t < 8; t++) begin
            mode_r = $urandom_range(0, 2);
            key    = {rand128(), rand128()};
            pt_r   = rand128();
            kv_r   = expand_key(key, 4 + 2 * mode_r);
            launch(2'(mode_r), pt_r, kv_r, "random");
            run_to_done(10 + 2 * mode_r, "random", 1'b1, 1'b1, 1'b0, 2'b00, 128'(0), kv_r);
            check("random ciphertext", o_state, ref_cipher(pt_r, kv_r, 10 + 2 * mode_r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_ladder_multimode.md
# aes_round_ladder_multimode

Sequential AES cipher round ladder that runs one round per enabled clock. The key length is selected at run time: AES-128, AES-192 or AES-256, giving 10, 12 or 14 rounds. The block sits between the key-expansion block and the GCTR/GHASH datapath and takes a pre-expanded round-key vector. Compared with the fixed 14-round ladder, it adds run-time mode selection, latching of inputs at launch, a busy/accept handshake with back-to-back launch, a held output register and rejection of illegal modes.

## Interface
- NB_BYTE, 8, bits per byte.
- N_BYTES, 16, bytes per state; N_BYTES/4 rows.
- N_ROUNDS_MAX, 14, largest supported round count; sizes the key vector and the round counter.
- i_clock  in  1  single clock.
- i_reset  in  1  reset; synchronous, active-high.
- i_valid  in  1  clock enable; when low, all state freezes.
- i_trigger  in  1  launch request; qualified by i_valid.
- i_mode  in  2  key length: 00=AES-128 (10 rounds), 01=AES-192 (12), 10=AES-256 (14), 11=illegal.
- i_state  in  N_BYTES*NB_BYTE  plaintext; bits [MSB -: 8] are byte s0,0.
- i_round_key_vector  in  N_BYTES*NB_BYTE*(N_ROUNDS_MAX+1)  round key k at bits [k*NB_STATE +: NB_STATE]; unused upper keys are ignored.
- o_state  out  N_BYTES*NB_BYTE  last ciphertext; holds until the next completion.
- o_state_ready  out  1  completion strobe.
- o_busy  out  1  when low, a trigger in this cycle is accepted.
- o_mode_error  out  1  strobe for a rejected launch.

## Operation
- States: IDLE and RUN. A round counter rnd of width clog2(N_ROUNDS_MAX+1) and a latched round count nr.
- Accept condition: i_valid & i_trigger & ~o_busy.
  - o_busy = RUN & ~(rnd==nr), so a launch is also accepted in the final-round cycle (back-to-back launch).
- On accept:
  - Latch the key vector and nr from i_mode.
  - state_reg <= i_state ^ key0.
  - rnd <= 1; go to RUN.
- RUN, on each enabled edge:
  - Compute state_reg <= round(state_reg, key[rnd], last = (rnd==nr)). The last round omits MixColumns.
  - rnd increments.
- When rnd==nr:
  - o_state <= round result; o_state_ready <= 1.
  - If no accept in the same cycle, go to IDLE.
- Illegal mode (11, or a mode whose rounds exceed N_ROUNDS_MAX) with i_valid & i_trigger & ~o_busy:
  - Launch is ignored.
  - o_mode_error <= 1 for one enabled cycle.
  - State, o_state and o_busy are unchanged.
- Trigger while o_busy=1 is ignored silently: no restart and no error.
- i_valid low freezes rnd, state_reg, the outputs and the strobes.
- Reset, including mid-operation: state IDLE, rnd=0, o_state=0, o_state_ready=0, o_busy=0, o_mode_error=0. Any in-flight block is discarded.

## Timing
- Launch accepted at enabled edge E. Ciphertext is in o_state and o_state_ready=1 after enabled edge E+nr: latency 10/12/14 enabled cycles.
- Strobes are registered and last exactly one enabled cycle. They clear at the next enabled edge and are held while i_valid is low.
- Throughput is one block per nr enabled cycles with back-to-back launch.
- After a launch, the inputs may change freely.
- o_busy is combinational from registers only, with no input paths.
- The round datapath is combinational per round, with a single state register. There is no pipelining inside a round.

## Structure
- Shared package aes_pkg holds:
  - the mode encodings;
  - the round-count function mode_to_nr;
  - the S-box constant table;
  - NB_STATE, N_COLS and the xtime helper.
- One sub-module: aes_round_comb, a purely combinational SubBytes/ShiftRows/MixColumns/AddRoundKey with an i_last_stage_flag. It is instantiated once.
- Top level: controller, key latch/mux and output register; 200-300 lines in total.

## Test plan
FIPS-197 App. C vectors are used throughout; the bench expands the keys with its reference model.
- AES-128: pt 00112233445566778899aabbccddeeff, key 000102…0f, mode 00 -> o_state 69c4e0d86a7b0430d8cdb78070b4c55a with o_state_ready 10 cycles after the launch edge.
- AES-192: key 000102…17, mode 01 -> dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles.
- AES-256: key 000102…1f, mode 10 -> 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
- Back-to-back launch and stalls:
  - AES-128 launch, then an AES-256 launch on the final-round cycle -> both ciphertexts correct, ready strobes 10 and 14 cycles apart.
  - Randomly deassert i_valid -> results unchanged, latency counted in enabled cycles only.
- Triggers while busy, and with mode 11:
  - Triggers during RUN with different pt -> ignored; result matches the first block.
  - Mode 11 trigger from IDLE -> o_mode_error pulses for one cycle, o_busy stays 0, o_state holds its previous value.
- Reset at round 5 of an AES-256 run -> all outputs are 0 next cycle and there is no ready strobe; an immediately following AES-128 run is correct.
